// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter.
// Round-robin grant between requesters A and B. The accepted write is
// registered onto the register-file write port one cycle later. Writes to
// register 0 are accepted but dropped, and a saturating counter tracks the
// writes that were actually committed.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  wrenable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  last_grant,
    output logic [CNT_WIDTH-1:0]  write_count
);

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  grant_a, grant_b, xfer, commit;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant decision: a tie goes to whichever side did not win last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !stall) begin
            if (a_valid && b_valid) begin
                grant_a = last_q;
                grant_b = !last_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Next-state for the write port, grant pointer and commit counter.
    // When the write is discarded or there is no transfer, the write port
    // keeps its last address and data.
    always_comb begin
        sel_addr = grant_b ? b_addr : a_addr;
        sel_data = grant_b ? b_data : a_data;
        xfer     = grant_a || grant_b;
        commit   = xfer && (sel_addr != '0);

        we_d   = commit;
        addr_d = addr_q;
        data_d = data_q;
        last_d = last_q;
        cnt_d  = cnt_q;

        if (xfer) begin
            last_d = grant_b;
        end
        if (commit) begin
            addr_d = sel_addr;
            data_d = sel_data;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers. On reset the pointer is set to B, so A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wrenable    = we_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign last_grant  = last_q;
    assign write_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal
// expectations, followed by randomized traffic checked against a
// behavioural model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        wrenable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        last_grant;
    logic [7:0]  write_count;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit          m_we;
    int unsigned m_addr, m_data;
    bit          m_last;
    int          m_cnt;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wrenable(wrenable), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_grant(last_grant), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the ready outputs against the
    // model's grant, advance the model at the edge, then check the
    // registered outputs.
    task automatic cycle(input bit rst, input bit stl,
                         input bit av, input int unsigned aa, input int unsigned ad,
                         input bit bv, input int unsigned ba, input int unsigned bd);
        bit ga, gb;
        int unsigned wa, wd;
        @(negedge clk);
        reset = rst; stall = stl;
        a_valid = av; a_addr = aa[4:0]; a_data = ad;
        b_valid = bv; b_addr = ba[4:0]; b_data = bd;
        #1;
        ga = 0; gb = 0;
        if (!rst && !stl) begin
            if (av && bv) begin
                if (m_last) ga = 1; else gb = 1;
            end else if (av) ga = 1;
            else if (bv) gb = 1;
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        @(posedge clk);
        if (rst) begin
            m_we = 0; m_addr = 0; m_data = 0; m_last = 1; m_cnt = 0;
        end else begin
            m_we = 0;
            if (ga || gb) begin
                m_last = gb;
                wa = ga ? (aa % 32) : (ba % 32);
                wd = ga ? ad : bd;
                if (wa != 0) begin
                    m_we = 1; m_addr = wa; m_data = wd;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
        chk("wrenable", wrenable, m_we);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("last_grant", last_grant, m_last);
        chk("write_count", write_count, m_cnt);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; stall = 0;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_last = 1; m_cnt = 0;

        // reset state, with both requesters valid during reset
        cycle(1, 0, 1, 5, 9, 1, 6, 10);
        chk("rst_wrenable", wrenable, 0);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_count", write_count, 0);

        // single write from A
        cycle(0, 0, 1, 3, 123456789, 0, 0, 0);
        chk("single_we", wrenable, 1);
        chk("single_addr", wr_addr, 3);
        chk("single_data", wr_data, 123456789);
        chk("single_count", write_count, 1);
        idle();
        chk("idle_we", wrenable, 0);
        chk("idle_hold_addr", wr_addr, 3);

        // same-address tie: A first, then B
        do_reset();
        cycle(0, 0, 1, 4, 666666, 1, 4, 7);
        chk("tie1_data", wr_data, 666666);
        chk("tie1_last", last_grant, 0);
        cycle(0, 0, 0, 4, 666666, 1, 4, 7);
        chk("tie2_data", wr_data, 7);
        chk("tie2_last", last_grant, 1);
        chk("tie2_count", write_count, 2);

        // write to register 0 is accepted and dropped
        cycle(0, 0, 0, 0, 0, 1, 0, 55);
        chk("zero_we", wrenable, 0);
        chk("zero_count", write_count, 2);
        chk("zero_hold_data", wr_data, 7);

        // stall with both requesters valid
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 8, 1, 1, 9, 2);
            chk("stall_we", wrenable, 0);
        end
        cycle(0, 0, 1, 8, 1, 1, 9, 2);
        chk("unstall_addr", wr_addr, 8);

        // counter saturation
        do_reset();
        for (int i = 0; i < 258; i++)
            cycle(0, 0, 1, 1 + (i % 31), i, 0, 0, 0);
        chk("sat_count", write_count, 255);

        // reset right after a granted write
        cycle(0, 0, 1, 9, 99, 0, 0, 0);
        do_reset();
        chk("rst_after_we", wrenable, 0);
        chk("rst_after_addr", wr_addr, 0);
        chk("rst_after_count", write_count, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, av, bv;
            int unsigned aa, ba;
            r  = ($urandom_range(99) < 2);
            s  = ($urandom_range(99) < 15);
            av = ($urandom_range(99) < 65);
            bv = ($urandom_range(99) < 65);
            aa = ($urandom_range(9) == 0) ? 0 : $urandom_range(31);
            ba = ($urandom_range(9) == 0) ? 0 : $urandom_range(31);
            cycle(r, s, av, aa, $urandom, bv, ba, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
